// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector with a run controller.
// Scans a qualified bit stream for a configurable pattern, emits a same-cycle
// match pulse, counts matches and stops itself once the match target is reached.
module seq_detect_ctrl #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1011,
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               din_valid,
    input  logic               din,
    output logic               dout,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    state_t               state_q,   state_d;
    logic [MAX_LEN-1:0]   pattern_q, pattern_d;
    logic [3:0]           len_q,     len_d;
    logic                 overlap_q, overlap_d;
    logic [CNT_W-1:0]     target_q,  target_d;
    // Only len-1 past bits are ever compared, so MAX_LEN-1 bits of history suffice.
    logic [MAX_LEN-2:0]   hist_q,    hist_d;
    logic [3:0]           fill_q,    fill_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 err_q,     err_d;

    logic [MAX_LEN-1:0]   win;
    logic [MAX_LEN-1:0]   win_mask;
    logic                 len_ok;
    logic                 fill_ok;
    logic                 match;
    logic [CNT_W-1:0]     cnt_inc;

    // Per-bit mask selecting the low len bits of the window and pattern.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign win_mask[gi] = (4'(gi) < len_q);
        end
    endgenerate

    // Match detection: newest bit lands in bit 0, older history above it.
    always_comb begin
        win     = {hist_q, din};
        len_ok  = (len_q != 4'd0) && (len_q <= MAX_LEN_L);
        fill_ok = (fill_q >= (len_q - 4'd1));
        match   = (state_q == S_RUN) && din_valid && !abort && fill_ok &&
                  ((win & win_mask) == (pattern_q & win_mask));
        cnt_inc = cnt_q + 1'b1;
    end

    // Next-state logic for the run controller, config registers and history.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        target_d  = target_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        case (state_q)
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    hist_d  = '0;
                    fill_d  = '0;
                end else if (din_valid) begin
                    hist_d = win[MAX_LEN-2:0];
                    fill_d = (fill_q < MAX_LEN_L) ? fill_q + 4'd1 : fill_q;
                    if (match) begin
                        // Unlimited runs saturate; targeted runs stop before wrapping.
                        if (!((target_q == '0) && (cnt_q == '1))) begin
                            cnt_d = cnt_inc;
                        end
                        if (!overlap_q) begin
                            fill_d = '0;
                        end
                        if ((target_q != '0) && (cnt_inc == target_q)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    len_d     = cfg_len;
                    overlap_d = cfg_overlap;
                    target_d  = cfg_target;
                end
                // Start is qualified against the length already held, so a write
                // in the same cycle only affects the following start.
                if (abort) begin
                    state_d = S_IDLE;
                    hist_d  = '0;
                    fill_d  = '0;
                end else if (start) begin
                    if (!len_ok) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        hist_d  = '0;
                        fill_d  = '0;
                    end
                end
            end
        endcase
    end

    // State register with synchronous reset to the power-on configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pattern_q <= RST_PATTERN;
            len_q     <= 4'(RST_LEN);
            overlap_q <= RST_OVERLAP;
            target_q  <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            target_q  <= target_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign dout      = match;
    assign match_cnt = cnt_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: a vector table, directed corner
// sequences and constrained-random traffic against a bit-queue reference model.
module tb_seq_detect_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start;
    logic       abort;
    logic       din_valid;
    logic       din;
    logic       dout;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;
    logic       err;

    seq_detect_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_target (cfg_target),
        .start      (start),
        .abort      (abort),
        .din_valid  (din_valid),
        .din        (din),
        .dout       (dout),
        .match_cnt  (match_cnt),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit last_dout;

    // Reference model: mode 0 idle, 1 running, 2 finished.
    int       m_mode;
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    int       m_tgt;
    int       m_cnt;
    bit       m_err;
    bit       seen[$];   // bits received since the run (or last non-overlap match) began

    typedef struct {
        bit st;
        bit dv;
        bit d;
        bit e_dout;
        bit e_busy;
        int e_cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
        m_tgt = 0; m_cnt = 0; m_err = 1'b0;
        seen.delete();
    endtask

    // A match means the newest len bits equal the low len bits of the pattern.
    function automatic bit model_match();
        if (m_mode != 1 || !din_valid || abort) return 1'b0;
        if (m_len < 1 || seen.size() < m_len - 1) return 1'b0;
        if (din != m_pat[0]) return 1'b0;
        for (int k = 1; k < m_len; k++)
            if (seen[seen.size() - k] != m_pat[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit hit);
        bit legal;
        legal = (m_len >= 1 && m_len <= 8);
        if (rst) begin
            model_reset();
            return;
        end
        m_err = 1'b0;
        if (m_mode == 1) begin
            if (abort) begin
                m_mode = 0;
                seen.delete();
            end else if (din_valid) begin
                seen.push_back(din);
                if (seen.size() > 8) void'(seen.pop_front());
                if (hit) begin
                    if (!(m_tgt == 0 && m_cnt == 255)) m_cnt++;
                    if (!m_ovl) seen.delete();
                    if (m_tgt != 0 && m_cnt == m_tgt) m_mode = 2;
                end
            end
        end else begin
            if (abort) begin
                m_mode = 0;
                seen.delete();
            end else if (start) begin
                if (!legal) m_err = 1'b1;
                else begin
                    m_mode = 1; m_cnt = 0; seen.delete();
                end
            end
            if (cfg_we) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len);
                m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
            end
        end
    endtask

    // One clock: check dout mid-cycle, advance the model on the edge, then
    // check registered outputs and drop all single-cycle controls.
    task automatic clk_step();
        bit hit;
        @(negedge clk);
        hit = model_match();
        last_dout = dout;
        chk("dout", int'(dout), int'(hit));
        @(posedge clk);
        model_step(hit);
        #1;
        chk("busy", int'(busy), int'(m_mode == 1));
        chk("done", int'(done), int'(m_mode == 2));
        chk("match_cnt", int'(match_cnt), m_cnt);
        chk("err", int'(err), int'(m_err));
        rst = 1'b0; cfg_we = 1'b0; start = 1'b0; abort = 1'b0; din_valid = 1'b0;
    endtask

    task automatic ctl(input bit st, input bit ab);
        start = st; abort = ab;
        clk_step();
    endtask

    task automatic cfg(input bit [7:0] p, input bit [3:0] l, input bit o, input bit [7:0] t);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
        clk_step();
    endtask

    task automatic send(input bit d, input bit e, input string nm);
        din_valid = 1'b1; din = d;
        clk_step();
        chk(nm, int'(last_dout), int'(e));
    endtask

    initial begin
        bit [3:0]  s1_bits;
        bit [11:0] s3_bits;
        bit [6:0]  s1b;
        bit [6:0]  s1e;
        int        s1c[7];

        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_target = '0; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 1'b0;
        s1b = 7'b1011011;   // sent MSB first
        s1e = 7'b0001001;
        s1c = '{0, 0, 0, 1, 1, 1, 2};
        tbl[0] = '{st: 1'b1, dv: 1'b0, d: 1'b0, e_dout: 1'b0, e_busy: 1'b1, e_cnt: 0};
        for (int i = 0; i < 7; i++)
            tbl[i+1] = '{st: 1'b0, dv: 1'b1, d: s1b[6-i], e_dout: s1e[6-i], e_busy: 1'b1, e_cnt: s1c[i]};

        // Reset state.
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(match_cnt), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_dout", int'(dout), 0);

        // Scenario 1: reset defaults, overlapping 1011 detection.
        for (int i = 0; i < 8; i++) begin
            start = tbl[i].st; din_valid = tbl[i].dv; din = tbl[i].d;
            clk_step();
            chk("t1_dout", int'(last_dout), int'(tbl[i].e_dout));
            chk("t1_busy", int'(busy), int'(tbl[i].e_busy));
            chk("t1_cnt", int'(match_cnt), tbl[i].e_cnt);
        end

        // Scenario 2: non-overlapping.
        ctl(1'b0, 1'b1);
        cfg(8'b0000_1011, 4'd4, 1'b0, 8'd0);
        ctl(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) send(s1b[6-i], (i == 3), "t2_dout");
        chk("t2_cnt", int'(match_cnt), 1);

        // Scenario 3: target of two ends the run.
        ctl(1'b0, 1'b1);
        cfg(8'b0000_1011, 4'd4, 1'b1, 8'd2);
        ctl(1'b1, 1'b0);
        s3_bits = 12'b1011_1011_1011;
        for (int i = 0; i < 12; i++) begin
            send(s3_bits[11-i], (i == 3 || i == 7), "t3_dout");
            if (i == 7) begin
                chk("t3_done", int'(done), 1);
                chk("t3_busy", int'(busy), 0);
            end
        end
        chk("t3_cnt", int'(match_cnt), 2);

        // Scenario 4: idle cycles between bits, restarted from DONE.
        cfg(8'b0000_1011, 4'd4, 1'b1, 8'd0);
        ctl(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            clk_step();
            send(s1b[6-i], s1e[6-i], "t4_dout");
        end
        chk("t4_cnt", int'(match_cnt), 2);

        // Scenario 5a: illegal length rejected.
        ctl(1'b0, 1'b1);
        cfg(8'b0000_1011, 4'd0, 1'b1, 8'd0);
        ctl(1'b1, 1'b0);
        chk("t5_err", int'(err), 1);
        chk("t5_busy", int'(busy), 0);
        clk_step();
        chk("t5_err_pulse", int'(err), 0);

        // Scenario 5b: writes during RUN are ignored, for this run and the next.
        cfg(8'b0000_1011, 4'd4, 1'b1, 8'd0);
        ctl(1'b1, 1'b0);
        cfg(8'b0000_0000, 4'd1, 1'b0, 8'd0);
        s1_bits = 4'b1011;
        for (int i = 0; i < 4; i++) send(s1_bits[3-i], (i == 3), "t5_run_dout");
        ctl(1'b0, 1'b1);
        ctl(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(s1_bits[3-i], (i == 3), "t5_next_dout");

        // Scenario 6a: abort discards history.
        ctl(1'b0, 1'b1);
        ctl(1'b1, 1'b0);
        send(1'b1, 1'b0, "t6_pre"); send(1'b0, 1'b0, "t6_pre"); send(1'b1, 1'b0, "t6_pre");
        ctl(1'b0, 1'b1);
        chk("t6_abort_busy", int'(busy), 0);
        ctl(1'b1, 1'b0);
        send(1'b1, 1'b0, "t6_fresh1");
        send(1'b0, 1'b0, "t6_fresh2");
        send(1'b1, 1'b0, "t6_fresh3");
        send(1'b1, 1'b1, "t6_fresh4");

        // Scenario 6b: reset mid-run restores the default configuration.
        ctl(1'b0, 1'b1);
        cfg(8'b0000_0110, 4'd3, 1'b0, 8'd5);
        ctl(1'b1, 1'b0);
        send(1'b0, 1'b0, "t6b"); send(1'b1, 1'b0, "t6b"); send(1'b1, 1'b0, "t6b");
        send(1'b0, 1'b1, "t6b_hit");
        rst = 1'b1;
        clk_step();
        chk("t6b_rst_cnt", int'(match_cnt), 0);
        chk("t6b_rst_busy", int'(busy), 0);
        ctl(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(s1_bits[3-i], (i == 3), "t6b_def_pat");
        send(1'b0, 1'b0, "t6b_ovl"); send(1'b1, 1'b0, "t6b_ovl"); send(1'b1, 1'b1, "t6b_ovl");
        chk("t6b_cnt", int'(match_cnt), 2);
        chk("t6b_done", int'(done), 0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 299) == 0);
            cfg_we      = ($urandom_range(0, 19) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(1, 4));
            cfg_overlap = 1'($urandom);
            cfg_target  = 8'($urandom_range(0, 4));
            start       = ($urandom_range(0, 14) == 0);
            abort       = ($urandom_range(0, 59) == 0);
            din_valid   = ($urandom_range(0, 3) != 0);
            din         = 1'($urandom);
            clk_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
